// File: rtl/txn_record_assembler_pkg.sv
// Shared types and constants for the transaction record assembler and
// anything downstream that consumes its unpacked records.
package txn_pkg;

  localparam int TS_W      = 31;
  localparam int VAL_W     = 20;
  localparam int REC_BYTES = 7;
  localparam int REC_W     = 8 * REC_BYTES;
  localparam int TIMEOUT   = 255;

  // Bit positions inside the 56-bit packed record (first byte = [55:48])
  localparam int NW_BIT   = 55;
  localparam int TS_MSB   = 54;
  localparam int TS_LSB   = 24;
  localparam int IN_BIT   = 23;
  localparam int METH_MSB = 22;
  localparam int METH_LSB = 21;
  localparam int RSV_BIT  = 20;
  localparam int VAL_MSB  = 19;

  localparam logic [1:0] METH_A = 2'b10;
  localparam logic [1:0] METH_B = 2'b11;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic             dir_in;
    logic [1:0]       method;
    logic [VAL_W-1:0] value;
    logic             new_wallet;
  } txn_rec_t;

  function automatic txn_rec_t unpack_rec(input logic [REC_W-1:0] raw);
    txn_rec_t r;
    r.new_wallet = raw[NW_BIT];
    r.ts         = raw[TS_MSB:TS_LSB];
    r.dir_in     = raw[IN_BIT];
    r.method     = raw[METH_MSB:METH_LSB];
    r.value      = raw[VAL_MSB:0];
    return r;
  endfunction

endpackage

// File: rtl/txn_record_assembler_if.sv
// Byte-stream input and record output bundle of the assembler.
// master = upstream/downstream environment, slave = assembler.
interface txn_record_assembler_if;
  import txn_pkg::*;

  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [TS_W-1:0]  time_stamp;
  logic             in;
  logic [1:0]       method_field;
  logic [VAL_W-1:0] value;
  logic             new_wallet;
  logic             rec_valid;
  logic             rec_ready;
  logic             ts_error;
  logic             fmt_error;
  logic             timeout_err;
  logic [7:0]       drop_count;

  modport master (
    output byte_in, byte_valid, rec_ready,
    input  byte_ready, time_stamp, in, method_field, value, new_wallet,
           rec_valid, ts_error, fmt_error, timeout_err, drop_count
  );

  modport slave (
    input  byte_in, byte_valid, rec_ready,
    output byte_ready, time_stamp, in, method_field, value, new_wallet,
           rec_valid, ts_error, fmt_error, timeout_err, drop_count
  );
endinterface

// File: rtl/txn_out_reg.sv
// Single-entry valid/ready holding register for unpacked records.
module txn_out_reg
  import txn_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  txn_rec_t rec_i,
  input  logic     ready_i,
  output logic     valid_o,
  output txn_rec_t rec_o
);

  logic     valid_q, valid_d;
  txn_rec_t rec_q, rec_d;

  // Load wins over drain so a same-edge drain+load keeps valid high
  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    if (load_i) begin
      valid_d = 1'b1;
      rec_d   = rec_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign valid_o = valid_q;
  assign rec_o   = rec_q;

endmodule

// File: rtl/txn_record_assembler.sv
// Assembles 7-byte MSB-first transaction records, drops malformed,
// out-of-order and stalled records, and hands good ones to the scorer.
module txn_record_assembler
  import txn_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  txn_record_assembler_if.slave bus
);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  localparam logic [2:0] LAST_IDX    = 3'(REC_BYTES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          timer_q, timer_d;
  logic [REC_W-9:0]    asm_q, asm_d;
  logic [TS_W-1:0]     last_ts_q, last_ts_d;
  logic                ref_valid_q, ref_valid_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                ts_err_q, ts_err_d;
  logic                fmt_err_q, fmt_err_d;
  logic                to_err_q, to_err_d;

  logic                hs;
  logic                byte_ready;
  logic                load;
  logic                rec_valid;
  logic [REC_W-1:0]    raw;
  txn_rec_t            rec_new;
  txn_rec_t            rec_out;

  // Only the final byte stalls, and only while the output stage cannot take it
  assign byte_ready = (byte_cnt_q != LAST_IDX) || !rec_valid || bus.rec_ready;
  assign hs         = bus.byte_valid && byte_ready;
  assign raw        = {asm_q, bus.byte_in};
  assign rec_new    = unpack_rec(raw);

  // Next-state: byte collection, record checks, timeout and drop accounting
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    timer_d     = timer_q;
    asm_d       = asm_q;
    last_ts_d   = last_ts_q;
    ref_valid_d = ref_valid_q;
    drop_cnt_d  = drop_cnt_q;
    ts_err_d    = 1'b0;
    fmt_err_d   = 1'b0;
    to_err_d    = 1'b0;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          asm_d      = {asm_q[REC_W-17:0], bus.byte_in};
          byte_cnt_d = 3'd1;
          timer_d    = '0;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (hs) begin
          asm_d   = {asm_q[REC_W-17:0], bus.byte_in};
          timer_d = '0;
          if (byte_cnt_q == LAST_IDX) begin
            byte_cnt_d = '0;
            state_d    = S_IDLE;
            if (raw[RSV_BIT]) begin
              fmt_err_d = 1'b1;
            end else if (!rec_new.new_wallet && ref_valid_q &&
                         (rec_new.ts < last_ts_q)) begin
              ts_err_d = 1'b1;
            end else begin
              load        = 1'b1;
              last_ts_d   = rec_new.ts;
              ref_valid_d = 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (timer_q == TIMEOUT_CNT) begin
          to_err_d   = 1'b1;
          byte_cnt_d = '0;
          timer_d    = '0;
          state_d    = S_IDLE;
        end else if (!bus.byte_valid) begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        byte_cnt_d = '0;
        timer_d    = '0;
      end
    endcase

    if ((fmt_err_d || ts_err_d || to_err_d) && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Control state and pulses; the assembly shift register needs no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      timer_q     <= '0;
      last_ts_q   <= '0;
      ref_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
      ts_err_q    <= 1'b0;
      fmt_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      timer_q     <= timer_d;
      last_ts_q   <= last_ts_d;
      ref_valid_q <= ref_valid_d;
      drop_cnt_q  <= drop_cnt_d;
      ts_err_q    <= ts_err_d;
      fmt_err_q   <= fmt_err_d;
      to_err_q    <= to_err_d;
    end
    asm_q <= asm_d;
  end

  txn_out_reg u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .rec_i   (rec_new),
    .ready_i (bus.rec_ready),
    .valid_o (rec_valid),
    .rec_o   (rec_out)
  );

  assign bus.byte_ready   = byte_ready;
  assign bus.rec_valid    = rec_valid;
  assign bus.time_stamp   = rec_out.ts;
  assign bus.in           = rec_out.dir_in;
  assign bus.method_field = rec_out.method;
  assign bus.value        = rec_out.value;
  assign bus.new_wallet   = rec_out.new_wallet;
  assign bus.ts_error     = ts_err_q;
  assign bus.fmt_error    = fmt_err_q;
  assign bus.timeout_err  = to_err_q;
  assign bus.drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_txn_record_assembler.sv
// Directed bench for the transaction record assembler.
module tb_txn_record_assembler;
  import txn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  txn_record_assembler_if bus ();

  txn_record_assembler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and return 1 time unit after the edge that accepts it
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.byte_ready) begin
      checks++; fails++;
      $display("FAIL byte_accept: byte_ready stuck at %b, required 1", bus.byte_ready);
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_rec(input logic [55:0] r);
    logic [55:0] v;
    v = r;
    for (int i = 6; i >= 0; i--) send_byte(v[i*8 +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.rec_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (bus.rec_valid !== 1'b0) begin fails++; $display("FAIL reset_rec_valid: got %b, required 0", bus.rec_valid); end
    checks++; if (bus.drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop_count: got %0d, required 0", bus.drop_count); end
    checks++; if (bus.byte_ready !== 1'b1) begin fails++; $display("FAIL reset_byte_ready: got %b, required 1", bus.byte_ready); end
    checks++; if (bus.time_stamp !== 31'd0) begin fails++; $display("FAIL reset_time_stamp: got %h, required 0", bus.time_stamp); end
  endtask

  task automatic test_basic();
    send_rec(56'h633DF61FC0087F);
    checks++; if (bus.rec_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b, required 1", bus.rec_valid); end
    checks++; if (bus.time_stamp !== 31'h633DF61F) begin fails++; $display("FAIL basic_ts: got %h, required 633df61f", bus.time_stamp); end
    checks++; if (bus.in !== 1'b1) begin fails++; $display("FAIL basic_in: got %b, required 1", bus.in); end
    checks++; if (bus.method_field !== 2'b10) begin fails++; $display("FAIL basic_method: got %b, required 10", bus.method_field); end
    checks++; if (bus.value !== 20'h0087F) begin fails++; $display("FAIL basic_value: got %h, required 0087f", bus.value); end
    checks++; if (bus.new_wallet !== 1'b0) begin fails++; $display("FAIL basic_wallet: got %b, required 0", bus.new_wallet); end
    checks++; if (bus.drop_count !== 8'd0) begin fails++; $display("FAIL basic_drops: got %0d, required 0", bus.drop_count); end
    tick();
    checks++; if (bus.rec_valid !== 1'b0) begin fails++; $display("FAIL basic_drain: got %b, required 0", bus.rec_valid); end
  endtask

  task automatic test_ordering();
    send_rec(56'h633E1E33CC287F);
    checks++; if (bus.rec_valid !== 1'b1 || bus.value !== 20'hC287F) begin fails++; $display("FAIL order_first: valid %b value %h, required 1 c287f", bus.rec_valid, bus.value); end
    send_rec(56'h633DF61FC0087F);
    checks++; if (bus.ts_error !== 1'b1) begin fails++; $display("FAIL order_ts_error: got %b, required 1", bus.ts_error); end
    checks++; if (bus.rec_valid !== 1'b0) begin fails++; $display("FAIL order_no_valid: got %b, required 0", bus.rec_valid); end
    checks++; if (bus.drop_count !== 8'd1) begin fails++; $display("FAIL order_drops: got %0d, required 1", bus.drop_count); end
    tick();
    checks++; if (bus.ts_error !== 1'b0) begin fails++; $display("FAIL order_pulse_width: got %b, required 0", bus.ts_error); end
  endtask

  task automatic test_wallet();
    send_rec(56'hE33DF61FC0087F);
    checks++; if (bus.rec_valid !== 1'b1 || bus.new_wallet !== 1'b1) begin fails++; $display("FAIL wallet_accept: valid %b nw %b, required 1 1", bus.rec_valid, bus.new_wallet); end
    checks++; if (bus.time_stamp !== 31'h633DF61F) begin fails++; $display("FAIL wallet_ts: got %h, required 633df61f", bus.time_stamp); end
    send_rec(56'h633DF61FC0087F);
    checks++; if (bus.rec_valid !== 1'b1 || bus.new_wallet !== 1'b0) begin fails++; $display("FAIL wallet_equal_ts: valid %b nw %b, required 1 0", bus.rec_valid, bus.new_wallet); end
    checks++; if (bus.ts_error !== 1'b0 || bus.drop_count !== 8'd1) begin fails++; $display("FAIL wallet_no_drop: ts_err %b drops %0d, required 0 1", bus.ts_error, bus.drop_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [55:0] b;
    b = 56'h633E1E33CC2801;
    bus.rec_ready = 1'b0;
    send_rec(56'h633E1E33CC287F);
    checks++; if (bus.rec_valid !== 1'b1 || bus.value !== 20'hC287F) begin fails++; $display("FAIL bp_held: valid %b value %h, required 1 c287f", bus.rec_valid, bus.value); end
    for (int i = 6; i >= 1; i--) send_byte(b[i*8 +: 8]);
    bus.byte_in = b[7:0]; bus.byte_valid = 1'b1;
    repeat (3) tick();
    checks++; if (bus.byte_ready !== 1'b0) begin fails++; $display("FAIL bp_stall: byte_ready %b, required 0", bus.byte_ready); end
    checks++; if (bus.rec_valid !== 1'b1 || bus.value !== 20'hC287F || bus.time_stamp !== 31'h633E1E33) begin fails++; $display("FAIL bp_stable: valid %b value %h ts %h, required 1 c287f 633e1e33", bus.rec_valid, bus.value, bus.time_stamp); end
    bus.rec_ready = 1'b1;
    #1;
    checks++; if (bus.byte_ready !== 1'b1) begin fails++; $display("FAIL bp_release: byte_ready %b, required 1", bus.byte_ready); end
    tick();
    bus.byte_valid = 1'b0;
    checks++; if (bus.rec_valid !== 1'b1 || bus.value !== 20'hC2801) begin fails++; $display("FAIL bp_second: valid %b value %h, required 1 c2801", bus.rec_valid, bus.value); end
    tick();
    checks++; if (bus.rec_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b, required 0", bus.rec_valid); end
  endtask

  task automatic test_format_timeout();
    int n;
    send_rec(56'h633E1E33D0287F);
    checks++; if (bus.fmt_error !== 1'b1 || bus.rec_valid !== 1'b0) begin fails++; $display("FAIL fmt_pulse: fmt %b valid %b, required 1 0", bus.fmt_error, bus.rec_valid); end
    checks++; if (bus.drop_count !== 8'd2) begin fails++; $display("FAIL fmt_drops: got %0d, required 2", bus.drop_count); end
    send_byte(8'h63); send_byte(8'h3E); send_byte(8'h1E);
    n = 0;
    while (!bus.timeout_err && n < 400) begin
      tick();
      n++;
    end
    checks++; if (n < 255 || n > 256) begin fails++; $display("FAIL timeout_cycles: pulse after %0d idle cycles, required 255..256", n); end
    checks++; if (bus.drop_count !== 8'd3) begin fails++; $display("FAIL timeout_drops: got %0d, required 3", bus.drop_count); end
    send_rec(56'h633E1E33CC2855);
    checks++; if (bus.rec_valid !== 1'b1 || bus.value !== 20'hC2855) begin fails++; $display("FAIL timeout_recover: valid %b value %h, required 1 c2855", bus.rec_valid, bus.value); end
    tick();
  endtask

  task automatic test_reset_saturation();
    send_byte(8'h63); send_byte(8'h3E); send_byte(8'h1E); send_byte(8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.rec_valid !== 1'b0 || bus.drop_count !== 8'd0) begin fails++; $display("FAIL midrst_clear: valid %b drops %0d, required 0 0", bus.rec_valid, bus.drop_count); end
    send_rec(56'h633DF61FC0087F);
    checks++; if (bus.rec_valid !== 1'b1 || bus.time_stamp !== 31'h633DF61F || bus.drop_count !== 8'd0) begin fails++; $display("FAIL midrst_accept: valid %b ts %h drops %0d, required 1 633df61f 0", bus.rec_valid, bus.time_stamp, bus.drop_count); end
    tick();
    for (int i = 0; i < 300; i++) begin
      send_rec(56'h633E1E33D0287F);
      if (i == 253) begin
        checks++; if (bus.drop_count !== 8'd254) begin fails++; $display("FAIL sat_254: got %0d, required 254", bus.drop_count); end
      end
      if (i == 254) begin
        checks++; if (bus.drop_count !== 8'd255) begin fails++; $display("FAIL sat_255: got %0d, required 255", bus.drop_count); end
      end
    end
    checks++; if (bus.drop_count !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d, required 255", bus.drop_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ordering();
    test_wallet();
    test_back_to_back();
    test_format_timeout();
    test_reset_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
